cpumc_arbiter: RTL
==================

# cpumc_arbiter

Sequences and shares the CPU memory bus (PRG cart, WRAM, PPU register window) between the rp2a03 CPU and the HCI debug host. It replaces the static `hci_active` multiplexer with a request/grant handshake and stalls the CPU via its ready input while the host owns the bus. Host accesses are bounded so CPU execution is never starved outside a debug break.

## Interface

**Parameters**
- `BURST_MAX`, default 4: maximum consecutive host accesses before the bus is forcibly returned to the CPU. Valid range 1–15.
- `CPU_SLOT`, default 2: minimum number of CPU-owned cycles after a forced release. Valid range 1–15.

**Ports**
- `clk_in` in 1: system clock (100 MHz domain). One clock only.
- `rst_in` in 1: synchronous, active-high reset.
- `cpu_a_in` in 16; `cpu_r_nw_in` in 1; `cpu_d_in` in 8: CPU bus request.
- `cpu_rdy_out` out 1: CPU ready. 0 stalls the CPU.
- `host_req_in` in 1: host access request. Level signal, held until granted.
- `host_lock_in` in 1: host debug break. While 1, the host keeps bus ownership.
- `host_a_in` in 16; `host_r_nw_in` in 1; `host_d_in` in 8: host access payload.
- `host_gnt_out` out 1: one-cycle pulse; the payload was consumed this cycle.
- `host_ack_out` out 1: one-cycle pulse; `host_d_out` is valid.
- `host_d_out` out 8: captured read data (also captured on writes).
- `bus_a_out` out 16; `bus_r_nw_out` out 1; `bus_d_out` out 8: shared bus drive.
- `bus_d_in` in 8: OR-combined read data from the memory blocks (one-cycle latency).
- `owner_out` out 1: 0 = CPU owns the bus, 1 = host owns the bus.

## Operation

**States:** CPU, STALL, ACCESS, CAPTURE, HOLD, RELEASE.

- **CPU:** bus = CPU signals, `cpu_rdy_out`=1, `owner_out`=0. If `host_req_in` or `host_lock_in` is high and the slot counter is 0, go to STALL.
- **STALL:** `cpu_rdy_out`=0. Address comes from the CPU, `bus_r_nw_out` is forced to 1 so no write repeats. `owner_out`=1.
  - If `host_req_in`, go to ACCESS; otherwise go to HOLD.
- **ACCESS:** bus = `host_a_in`/`host_r_nw_in`/`host_d_in`, taken directly from the held inputs. `host_gnt_out`=1. Burst counter increments. Go to CAPTURE.
- **CAPTURE:** register `host_d_out` ← `bus_d_in`; `host_ack_out`=1 on the following cycle. Address is held, `bus_r_nw_out`=1. Next state:
  - `host_req_in` and (lock or count<`BURST_MAX`) → ACCESS.
  - Otherwise lock → HOLD.
  - Otherwise → RELEASE.
- **HOLD:** host owns the bus, `bus_r_nw_out`=1, CPU stalled.
  - `host_req_in` → ACCESS (the burst limit is checked as in CAPTURE).
  - `!host_lock_in && !host_req_in` → RELEASE.
- **RELEASE:** `cpu_rdy_out` returns to 1 next cycle. Burst counter ← 0. Slot counter ← `CPU_SLOT` if the release was forced by the burst limit, else 0. Go to CPU.

**Rules and boundaries:**
- In the CPU state the slot counter decrements to 0; the host is not re-granted while it is nonzero.
- During a lock, `BURST_MAX` is ignored. The counter still saturates at 15.
- The host may change its payload only in the cycle after `host_gnt_out`. A back-to-back request presented then is granted 2 cycles after the previous grant.
- `host_req_in` and `host_lock_in` rising in the same cycle behave as a request.
- Lock falling mid-burst: the current access completes. The burst limit then applies to any further accesses.
- Bus writes occur only in the CPU state (CPU write) or the ACCESS state (host write). All other states force a read.

## Timing

- **Reset values:** state CPU; `cpu_rdy_out`=1; `host_gnt_out`=0; `host_ack_out`=0; `host_d_out`=0; `owner_out`=0; both counters 0. The bus follows the CPU inputs.
- **Reset mid-operation:** the next cycle is CPU state. Pending grant/ack are dropped. A still-asserted `host_req_in` restarts at STALL one cycle after reset deasserts.
- **Host latency:** with `host_req_in` sampled high in the CPU state at cycle N:
  - STALL at N+1 (`cpu_rdy_out`=0 from N+1).
  - `host_gnt_out` at N+2.
  - `host_ack_out` with data at N+4.
- **Burst throughput:** one access per 2 cycles.
- **Release:** from RELEASE at cycle M, `cpu_rdy_out`=1 from M+1.
- State and all handshake outputs are registered. Bus outputs are a combinational mux selected by the registered state.

## Configuration

- **`CPUMC_ARB_FAIRNESS_EN`**
  - **Defined:** the `BURST_MAX` limit and `CPU_SLOT` reservation are enforced as described above.
  - **Undefined:** the burst and slot counters are not built. The host keeps the bus while `host_req_in` or `host_lock_in` is high. CAPTURE never force-releases, and the CPU state re-grants immediately.

## Test plan

- **Single host read:** after reset, CPU reads 0x8000. At N, host_req with a=0x0123, r_nw=1; memory returns 0x5A.
  - `cpu_rdy_out`=0 at N+1; gnt at N+2 with `bus_a_out`=0x0123; ack at N+4 with `host_d_out`=0x5A.
  - `cpu_rdy_out`=1 at N+5.
- **Host write, no spurious CPU write:** CPU writing 0x0200 when the host requests a write of 0xA5 to 0x0300.
  - Exactly one write is seen at 0x0300 (data 0xA5), in the ACCESS cycle.
  - During STALL, `bus_r_nw_out`=1.
- **Fairness (macro defined, `BURST_MAX`=4, `CPU_SLOT`=2):** host_req held for 10 accesses.
  - 4 grants spaced 2 cycles apart, then `cpu_rdy_out`=1 for ≥2 cycles, then the next grant.
- **Lock:** `host_lock_in`=1 with 8 requests → 8 consecutive grants, no CPU cycles between them. Lock dropped → `cpu_rdy_out`=1 two cycles later.
- **Macro undefined:** same stimulus as the fairness test → 10 consecutive grants with no CPU slot.
- **Reset mid-burst:** `rst_in` pulsed during CAPTURE.
  - Next cycle: `owner_out`=0, `host_ack_out`=0, `host_d_out`=0.
  - With `host_req_in` still high, STALL follows one cycle after reset releases.

Source files
------------

// File: rtl/cpumc_arbiter.sv
// CPU/host bus arbiter for the CPU memory bus: request/grant handshake that stalls the CPU while the host owns the bus.
// Optional fairness (burst limit + CPU slot reservation) is built only when CPUMC_ARB_FAIRNESS_EN is defined.
module cpumc_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned CPU_SLOT  = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic        cpu_rdy_out,
  input  logic        host_req_in,
  input  logic        host_lock_in,
  input  logic [15:0] host_a_in,
  input  logic        host_r_nw_in,
  input  logic [7:0]  host_d_in,
  output logic        host_gnt_out,
  output logic        host_ack_out,
  output logic [7:0]  host_d_out,
  output logic [15:0] bus_a_out,
  output logic        bus_r_nw_out,
  output logic [7:0]  bus_d_out,
  input  logic [7:0]  bus_d_in,
  output logic        owner_out
);

  if (BURST_MAX == 0 || BURST_MAX > 15 || CPU_SLOT == 0 || CPU_SLOT > 15) begin : g_param_check
    $error("cpumc_arbiter: BURST_MAX and CPU_SLOT must be in 1..15");
  end

  typedef enum logic [2:0] {
    ST_CPU,
    ST_STALL,
    ST_ACCESS,
    ST_CAPTURE,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_slot_free;
  logic        w_burst_ok;
  logic        r_rdy;
  logic        r_owner;
  logic        r_gnt;
  logic        r_ack;
  logic [7:0]  r_host_d;
  logic [15:0] r_hold_a;
  logic [7:0]  r_hold_d;
  logic [15:0] w_bus_a;
  logic        w_bus_rnw;
  logic [7:0]  w_bus_d;

`ifdef CPUMC_ARB_FAIRNESS_EN
  localparam logic [3:0] LP_BURST_MAX = 4'(BURST_MAX);
  localparam logic [3:0] LP_CPU_SLOT  = 4'(CPU_SLOT);

  logic [3:0] r_burst;
  logic [3:0] r_slot;
  logic       r_forced;
  logic       w_forced;

  assign w_slot_free = (r_slot == '0);
  assign w_burst_ok  = host_lock_in || (r_burst < LP_BURST_MAX);
  assign w_forced    = ((r_state == ST_CAPTURE) || (r_state == ST_HOLD)) &&
                       host_req_in && !w_burst_ok;

  // r_forced remembers why we entered RELEASE so the slot reservation is only granted on a forced release.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_burst  <= '0;
      r_slot   <= '0;
      r_forced <= 1'b0;
    end else begin
      if (r_state != ST_RELEASE) r_forced <= w_forced;

      if (r_state == ST_RELEASE) r_burst <= '0;
      else if (r_state == ST_ACCESS && r_burst != '1) r_burst <= r_burst + 4'd1;

      if (r_state == ST_RELEASE) r_slot <= r_forced ? LP_CPU_SLOT : '0;
      else if (r_state == ST_CPU && r_slot != '0) r_slot <= r_slot - 4'd1;
    end
  end
`else
  assign w_slot_free = 1'b1;
  assign w_burst_ok  = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= ST_CPU;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CPU:     if ((host_req_in || host_lock_in) && w_slot_free) w_next = ST_STALL;
      ST_STALL:   w_next = host_req_in ? ST_ACCESS : ST_HOLD;
      ST_ACCESS:  w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        if (host_req_in && w_burst_ok) w_next = ST_ACCESS;
        else if (host_lock_in)         w_next = ST_HOLD;
        else                           w_next = ST_RELEASE;
      end
      ST_HOLD: begin
        if (host_req_in)       w_next = w_burst_ok ? ST_ACCESS : ST_RELEASE;
        else if (!host_lock_in) w_next = ST_RELEASE;
      end
      ST_RELEASE: w_next = ST_CPU;
      default:    w_next = ST_CPU;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rdy    <= 1'b1;
      r_owner  <= 1'b0;
      r_gnt    <= 1'b0;
      r_ack    <= 1'b0;
      r_host_d <= '0;
      r_hold_a <= '0;
      r_hold_d <= '0;
    end else begin
      r_rdy   <= (w_next == ST_CPU);
      r_owner <= (w_next != ST_CPU);
      r_gnt   <= (w_next == ST_ACCESS);
      r_ack   <= (r_state == ST_CAPTURE);
      if (r_state == ST_CAPTURE) r_host_d <= bus_d_in;
      if (r_state == ST_STALL || r_state == ST_ACCESS) begin
        r_hold_a <= w_bus_a;
        r_hold_d <= w_bus_d;
      end
    end
  end

  always_comb begin
    w_bus_a   = r_hold_a;
    w_bus_rnw = 1'b1;
    w_bus_d   = r_hold_d;
    case (r_state)
      ST_CPU: begin
        w_bus_a   = cpu_a_in;
        w_bus_rnw = cpu_r_nw_in;
        w_bus_d   = cpu_d_in;
      end
      ST_STALL: begin
        w_bus_a = cpu_a_in;
        w_bus_d = cpu_d_in;
      end
      ST_ACCESS: begin
        w_bus_a   = host_a_in;
        w_bus_rnw = host_r_nw_in;
        w_bus_d   = host_d_in;
      end
      default: ;
    endcase
  end

  assign cpu_rdy_out  = r_rdy;
  assign owner_out    = r_owner;
  assign host_gnt_out = r_gnt;
  assign host_ack_out = r_ack;
  assign host_d_out   = r_host_d;
  assign bus_a_out    = w_bus_a;
  assign bus_r_nw_out = w_bus_rnw;
  assign bus_d_out    = w_bus_d;

endmodule
